// File: rtl/vpu_blit.sv
// Block-transfer engine (fill / ascending copy) and CPU-priority arbiter for the
// single vpu register port; owns an 8-byte register window of its own.
module vpu_blit (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       cpu_vcs,
    input  logic [3:0] cpu_vad,
    input  logic [7:0] cpu_vdi,
    input  logic       cpu_vrw,
    output logic       vpu_cs,
    output logic [3:0] vpu_ad,
    output logic [7:0] vpu_di,
    output logic       vpu_rw,
    input  logic [7:0] vpu_do
);

    typedef enum logic [3:0] {
        IDLE, SRC_HI, SRC_LO, SRC_WAIT, SRC_RD, DST_HI, DST_LO, DST_WR, GAP, FINISH
    } state_t;

    state_t      state;
    logic        busy, done, ien, mode;
    logic [12:0] src, dst, cnt;
    logic [12:0] wsrc, wdst, wcnt;
    logic [7:0]  fill, dbuf;

    logic        reg_wr, stat_rd, preempt;
    logic        eng_cs, eng_rw;
    logic [3:0]  eng_ad;
    logic [7:0]  eng_di;

    assign reg_wr  = cs && !rw;
    assign stat_rd = cs && rw && (AD == 3'd0);
    // A CPU access in these states disturbs the VPU address the engine set up.
    assign preempt = (state == SRC_WAIT) || (state == SRC_RD) ||
                     (state == DST_LO)   || (state == DST_WR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            ien   <= 1'b0;
            mode  <= 1'b0;
            irq   <= 1'b0;
            src   <= '0;
            dst   <= '0;
            cnt   <= '0;
            fill  <= '0;
            wsrc  <= '0;
            wdst  <= '0;
            wcnt  <= '0;
            dbuf  <= '0;
        end else begin
            if (stat_rd) begin
                done <= 1'b0;
                irq  <= 1'b0;
            end
            if (reg_wr && !busy) begin
                case (AD)
                    3'd0: begin
                        ien  <= DI[2];
                        mode <= DI[1];
                        if (DI[0] && !DI[7]) begin
                            if (cnt == 13'd0) begin
                                done <= 1'b1;
                                irq  <= DI[2];
                            end else begin
                                busy  <= 1'b1;
                                done  <= 1'b0;
                                wsrc  <= src;
                                wdst  <= dst;
                                wcnt  <= cnt;
                                state <= DI[1] ? SRC_HI : DST_HI;
                            end
                        end
                    end
                    3'd1: src[12:8] <= DI[4:0];
                    3'd2: src[7:0]  <= DI;
                    3'd3: dst[12:8] <= DI[4:0];
                    3'd4: dst[7:0]  <= DI;
                    3'd5: cnt[12:8] <= DI[4:0];
                    3'd6: cnt[7:0]  <= DI;
                    default: fill   <= DI;
                endcase
            end

            if (busy && reg_wr && (AD == 3'd0) && DI[7]) begin
                busy  <= 1'b0;
                state <= IDLE;
            end else if (busy && cpu_vcs) begin
                if (preempt)
                    state <= mode ? SRC_HI : DST_HI;
            end else if (busy) begin
                case (state)
                    SRC_HI:   state <= SRC_LO;
                    SRC_LO:   state <= SRC_WAIT;
                    SRC_WAIT: state <= SRC_RD;
                    SRC_RD: begin
                        dbuf  <= vpu_do;
                        state <= DST_HI;
                    end
                    DST_HI:   state <= DST_LO;
                    DST_LO:   state <= DST_WR;
                    DST_WR:   state <= GAP;
                    GAP: begin
                        if (mode)
                            wsrc <= wsrc + 13'd1;
                        wdst <= wdst + 13'd1;
                        wcnt <= wcnt - 13'd1;
                        if (wcnt == 13'd1)
                            state <= FINISH;
                        else
                            state <= mode ? SRC_HI : DST_HI;
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        irq   <= ien;
                        state <= IDLE;
                    end
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        eng_cs = 1'b0;
        eng_ad = 4'd0;
        eng_di = 8'd0;
        eng_rw = 1'b1;
        case (state)
            SRC_HI: begin eng_cs = 1'b1; eng_rw = 1'b0; eng_ad = 4'd1; eng_di = {3'b0, wsrc[12:8]}; end
            SRC_LO: begin eng_cs = 1'b1; eng_rw = 1'b0; eng_ad = 4'd2; eng_di = wsrc[7:0]; end
            SRC_RD: begin eng_cs = 1'b1; eng_rw = 1'b1; eng_ad = 4'd0; end
            DST_HI: begin eng_cs = 1'b1; eng_rw = 1'b0; eng_ad = 4'd1; eng_di = {3'b0, wdst[12:8]}; end
            DST_LO: begin eng_cs = 1'b1; eng_rw = 1'b0; eng_ad = 4'd2; eng_di = wdst[7:0]; end
            DST_WR: begin eng_cs = 1'b1; eng_rw = 1'b0; eng_ad = 4'd0; eng_di = mode ? dbuf : fill; end
            default: ;
        endcase
    end

    assign vpu_cs = cpu_vcs ? 1'b1    : eng_cs;
    assign vpu_ad = cpu_vcs ? cpu_vad : eng_ad;
    assign vpu_di = cpu_vcs ? cpu_vdi : eng_di;
    assign vpu_rw = cpu_vcs ? cpu_vrw : eng_rw;

    always_comb begin
        case (AD)
            3'd0:    DO = {busy, done, 3'b0, ien, mode, 1'b0};
            3'd1:    DO = {3'b0, src[12:8]};
            3'd2:    DO = src[7:0];
            3'd3:    DO = {3'b0, dst[12:8]};
            3'd4:    DO = dst[7:0];
            3'd5:    DO = {3'b0, cnt[12:8]};
            3'd6:    DO = cnt[7:0];
            default: DO = fill;
        endcase
    end

endmodule

// File: tb/tb_vpu_blit.sv
// Directed bench for vpu_blit with a small behavioural VPU (address latch,
// auto-incrementing data port) standing in for the real vpu.
module tb_vpu_blit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] AD = 3'd0;
    logic [7:0] DI = 8'd0;
    logic [7:0] DO;
    logic       rw = 1'b1;
    logic       cs = 1'b0;
    logic       irq;
    logic       cpu_vcs = 1'b0;
    logic [3:0] cpu_vad = 4'd0;
    logic [7:0] cpu_vdi = 8'd0;
    logic       cpu_vrw = 1'b1;
    logic       vpu_cs;
    logic [3:0] vpu_ad;
    logic [7:0] vpu_di;
    logic       vpu_rw;
    logic [7:0] vpu_do;

    vpu_blit dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq),
        .cpu_vcs(cpu_vcs), .cpu_vad(cpu_vad), .cpu_vdi(cpu_vdi), .cpu_vrw(cpu_vrw),
        .vpu_cs(vpu_cs), .vpu_ad(vpu_ad), .vpu_di(vpu_di), .vpu_rw(vpu_rw), .vpu_do(vpu_do)
    );

    always #5 clk = ~clk;

    logic [7:0]  vram [0:8191];
    logic [12:0] vaddr = 13'd0;
    logic [11:0] wlog [$];
    int          pulses = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    assign vpu_do = vram[vaddr];

    always @(posedge clk) begin
        if (vpu_cs) begin
            if (!vpu_rw) begin
                case (vpu_ad)
                    4'd1: vaddr[12:8] <= vpu_di[4:0];
                    4'd2: vaddr[7:0]  <= vpu_di;
                    4'd0: begin
                        vram[vaddr] <= vpu_di;
                        vaddr       <= vaddr + 13'd1;
                    end
                    default: ;
                endcase
            end else if (vpu_ad == 4'd0) begin
                vaddr <= vaddr + 13'd1;
            end
        end
        if (vpu_cs && !cpu_vcs) begin
            pulses <= pulses + 1;
            if (!vpu_rw)
                wlog.push_back({vpu_ad, vpu_di});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1; AD = 3'd0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        cs = 1'b1; rw = 1'b1; AD = a;
        #1 d = DO;
        @(negedge clk);
        cs = 1'b0; AD = 3'd0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        AD = a;
        #1 d = DO;
    endtask

    task automatic cpu_vpu(input logic [3:0] a, input logic [7:0] d);
        cpu_vcs = 1'b1; cpu_vad = a; cpu_vdi = d; cpu_vrw = 1'b0;
        @(negedge clk);
        cpu_vcs = 1'b0; cpu_vrw = 1'b1;
    endtask

    task automatic wait_done(input string tag, output int k);
        logic [7:0] s;
        k = 0;
        peek(3'd0, s);
        while (!s[6] && k < 100) begin
            @(negedge clk);
            k++;
            peek(3'd0, s);
        end
        if (k >= 100)
            check({tag, "_timeout"}, 32'(k), 32'd0);
    endtask

    task automatic set_xfer(input logic [12:0] s, input logic [12:0] d, input logic [12:0] c);
        wr(3'd1, {3'b0, s[12:8]}); wr(3'd2, s[7:0]);
        wr(3'd3, {3'b0, d[12:8]}); wr(3'd4, d[7:0]);
        wr(3'd5, {3'b0, c[12:8]}); wr(3'd6, c[7:0]);
    endtask

    initial begin
        logic [7:0] v;
        int k, n0, p;

        // Reset state
        repeat (3) @(negedge clk);
        peek(3'd0, v); check("rst_ctrl", v, 8'h00);
        peek(3'd7, v); check("rst_fill", v, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_vcs", vpu_cs, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Fill 3 bytes at 0x0100
        wr(3'd7, 8'hAA);
        set_xfer(13'h0, 13'h0100, 13'd3);
        wlog.delete();
        wr(3'd0, 8'h01);
        peek(3'd0, v); check("fill_busy", v, 8'h80);
        check("fill_first_cs", vpu_cs, 1'b1);
        check("fill_first_ad", vpu_ad, 4'd1);
        check("fill_first_di", vpu_di, 8'h01);
        repeat (12) @(negedge clk);
        peek(3'd0, v); check("fill_not_done_12", v, 8'h80);
        @(negedge clk);
        peek(3'd0, v); check("fill_done_13", v, 8'h40);
        check("fill_log_len", wlog.size(), 9);
        if (wlog.size() == 9) begin
            check("fill_w0", wlog[0], 12'h101);
            check("fill_w1", wlog[1], 12'h200);
            check("fill_w2", wlog[2], 12'h0AA);
            check("fill_w4", wlog[4], 12'h201);
            check("fill_w7", wlog[7], 12'h202);
        end
        check("fill_vram100", vram[13'h100], 8'hAA);
        check("fill_vram102", vram[13'h102], 8'hAA);
        check("fill_irq", irq, 1'b0);
        rd(3'd0, v);

        // Copy 2 bytes 0x10 -> 0x20 with IEN
        cpu_vpu(4'd1, 8'h00); cpu_vpu(4'd2, 8'h10);
        cpu_vpu(4'd0, 8'h12); cpu_vpu(4'd0, 8'h34);
        check("cpu_preload", vram[13'h11], 8'h34);
        set_xfer(13'h0010, 13'h0020, 13'd2);
        wr(3'd0, 8'h07);
        check("copy_first_ad", vpu_ad, 4'd1);
        repeat (16) @(negedge clk);
        check("copy_irq_16", irq, 1'b0);
        @(negedge clk);
        check("copy_irq_17", irq, 1'b1);
        check("copy_vram20", vram[13'h20], 8'h12);
        check("copy_vram21", vram[13'h21], 8'h34);
        rd(3'd0, v); check("copy_status", v, 8'h46);
        check("copy_irq_cleared", irq, 1'b0);
        peek(3'd0, v); check("copy_done_cleared", v, 8'h06);

        // CPU contention during DST_WR of a fill
        wr(3'd7, 8'h55);
        set_xfer(13'h0, 13'h0200, 13'd2);
        wlog.delete();
        wr(3'd0, 8'h01);
        repeat (2) @(negedge clk);
        cpu_vcs = 1'b1; cpu_vad = 4'd3; cpu_vdi = 8'h5A; cpu_vrw = 1'b0;
        #1;
        check("cont_cs", vpu_cs, 1'b1);
        check("cont_ad", vpu_ad, 4'd3);
        check("cont_di", vpu_di, 8'h5A);
        check("cont_rw", vpu_rw, 1'b0);
        @(negedge clk);
        cpu_vcs = 1'b0; cpu_vrw = 1'b1;
        wait_done("cont", k);
        check("cont_cycles", k, 9);
        n0 = 0;
        foreach (wlog[i]) if (wlog[i][11:8] == 4'd0) n0++;
        check("cont_data_writes", n0, 2);
        check("cont_vram200", vram[13'h200], 8'h55);
        check("cont_vram201", vram[13'h201], 8'h55);
        rd(3'd0, v);

        // Wrap 0x1FFF -> 0x0000
        wr(3'd7, 8'h77);
        set_xfer(13'h0, 13'h1FFF, 13'd2);
        wlog.delete();
        wr(3'd0, 8'h01);
        wait_done("wrap", k);
        check("wrap_log_len", wlog.size(), 6);
        if (wlog.size() == 6) begin
            check("wrap_w0", wlog[0], 12'h11F);
            check("wrap_w1", wlog[1], 12'h2FF);
            check("wrap_w3", wlog[3], 12'h100);
            check("wrap_w4", wlog[4], 12'h200);
        end
        check("wrap_vram1fff", vram[13'h1FFF], 8'h77);
        check("wrap_vram0", vram[13'h0000], 8'h77);
        rd(3'd0, v);

        // CNT=0 start
        set_xfer(13'h0, 13'h0300, 13'd0);
        p = pulses;
        wr(3'd0, 8'h01);
        peek(3'd0, v); check("cnt0_done", v, 8'h40);
        repeat (5) @(negedge clk);
        check("cnt0_pulses", pulses - p, 0);
        rd(3'd0, v);

        // START and register writes while busy are ignored
        wr(3'd7, 8'h11);
        set_xfer(13'h0, 13'h0300, 13'd2);
        wr(3'd0, 8'h01);
        repeat (2) @(negedge clk);
        wr(3'd0, 8'h03);
        wr(3'd4, 8'h55);
        peek(3'd0, v); check("busy_start_ign", v, 8'h80);
        wait_done("busy", k);
        rd(3'd4, v); check("busy_dst_ign", v, 8'h00);
        check("busy_vram300", vram[13'h300], 8'h11);
        check("busy_vram301", vram[13'h301], 8'h11);
        rd(3'd0, v); check("busy_status", v, 8'h40);

        // ABORT mid-copy
        set_xfer(13'h0010, 13'h0400, 13'd2);
        wr(3'd0, 8'h07);
        repeat (3) @(negedge clk);
        wr(3'd0, 8'h80);
        p = pulses;
        peek(3'd0, v); check("abort_status", v, 8'h06);
        check("abort_irq", irq, 1'b0);
        repeat (20) @(negedge clk);
        check("abort_pulses", pulses - p, 0);
        check("abort_irq_late", irq, 1'b0);
        peek(3'd0, v); check("abort_status_late", v, 8'h06);

        // Reset mid-transfer
        set_xfer(13'h0, 13'h0500, 13'd5);
        wr(3'd0, 8'h05);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_vcs", vpu_cs, 1'b0);
        check("mrst_irq", irq, 1'b0);
        peek(3'd0, v); check("mrst_ctrl", v, 8'h00);
        peek(3'd7, v); check("mrst_fill", v, 8'h00);
        peek(3'd6, v); check("mrst_cnt", v, 8'h00);
        cpu_vcs = 1'b1; cpu_vad = 4'd5; cpu_vrw = 1'b1;
        #1;
        check("mrst_pass_cs", vpu_cs, 1'b1);
        check("mrst_pass_ad", vpu_ad, 4'd5);
        @(negedge clk);
        cpu_vcs = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_idle_vcs", vpu_cs, 1'b0);
        peek(3'd0, v); check("mrst_idle_ctrl", v, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vpu_blit.md
# vpu_blit

Block-transfer engine and bus arbiter in front of the `vpu` register port. It performs hardware fills and forward copies of video RAM by sequencing VPU register accesses (address MSB/LSB, data port), and shares the single VPU port between the CPU and the engine with CPU priority. It sits between the SuperIO chip-select decode and `vpu`, and owns its own 8-byte register window.

## Interface
Parameters: none.

- `clk`  in  1  system clock, same clock as `vpu` `clk`; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `AD`  in  3  blitter register select
- `DI`  in  8  CPU write data
- `DO`  out  8  CPU read data (combinational from registers)
- `rw`  in  1  1 = read, 0 = write
- `cs`  in  1  blitter register window select
- `irq`  out  1  transfer-complete interrupt
- `cpu_vcs`, `cpu_vad[3:0]`, `cpu_vdi[7:0]`, `cpu_vrw`  in  CPU request to VPU
- `vpu_cs`, `vpu_ad[3:0]`, `vpu_di[7:0]`, `vpu_rw`  out  to `vpu` `cs`/`AD`/`DI`/`rw`
- `vpu_do`  in  8  `vpu` `DO`

## Operation
- Registers:
  - $0 CTRL/STATUS.
    - Write: bit0 START, bit1 MODE (0 fill, 1 copy), bit2 IEN, bit7 ABORT.
    - Read: {BUSY, DONE, 3'b0, IEN, MODE, 0}.
  - $1/$2 SRC[12:8]/[7:0].
  - $3/$4 DST[12:8]/[7:0].
  - $5/$6 CNT[12:8]/[7:0].
  - $7 FILL value.
  - Upper unused bits read 0.
- Reset: all registers 0, state IDLE, `irq`=0, `DO` shows register 0 contents. Reset is honoured mid-transfer; it aborts immediately.
- Arbitration: `cpu_vcs`=1 passes the CPU request straight to the `vpu_*` outputs that cycle, and the engine stalls (state held). The engine drives `vpu_*` only when `cpu_vcs`=0.
- Write to SRC/DST/CNT/FILL while BUSY: ignored.
- START:
  - START while BUSY: ignored.
  - START with CNT=0: sets DONE, no VPU access.
  - Otherwise sets BUSY, clears DONE, and copies SRC/DST/CNT into working counters.
- FSM states: IDLE, SRC_HI, SRC_LO, SRC_WAIT, SRC_RD, DST_HI, DST_LO, DST_WR, GAP, FINISH.
- Fill byte sequence:
  - DST_HI: write $1 = {3'b0, dst[12:8]}.
  - DST_LO: write $2 = dst[7:0].
  - DST_WR: write $0 = FILL.
  - GAP: no access; dst+1, cnt-1.
- Copy byte sequence:
  - SRC_HI: write $1 = src MSB.
  - SRC_LO: write $2 = src LSB.
  - SRC_WAIT: no access.
  - SRC_RD: read $0, latch `vpu_do` into the data buffer.
  - DST_HI, DST_LO, then DST_WR writes the buffer.
  - GAP: src+1, dst+1, cnt-1.
- After GAP: cnt=0 goes to FINISH, otherwise start the next byte.
- FINISH: BUSY=0, DONE=1, `irq`=IEN, then IDLE.
- Preemption: a CPU grant while in SRC_WAIT/SRC_RD or DST_LO/DST_WR invalidates the VPU address. The engine restarts the current byte at its first state (SRC_HI in copy mode, DST_HI in fill mode). Counters are not advanced.
- Arithmetic: src and dst are 13-bit and wrap 0x1FFF→0x0000. Copy is ascending only; overlapping dst>src propagates data (documented).
- Side effect: the VPU VAddr is left pointing past the last accessed byte. Software reloads it.
- ABORT: the engine goes to IDLE on the next edge; BUSY=0, DONE unchanged, no irq.
- A status read ($0, `rw`=1) clears DONE and `irq` at the clock edge.
- Simultaneous DONE set and status read: the set wins.

## Timing
- START written in cycle N: BUSY reads 1 in N+1, and the first `vpu_cs` from the engine is in N+1.
- Throughput with no CPU contention: fill 4 clk/byte, copy 8 clk/byte.
- Each engine VPU access is exactly one clk with `vpu_cs`=1. GAP guarantees a non-access cycle after every $0 write, which lets the VPU write/increment pipeline settle.
- SRC_RD samples `vpu_do` at the end of the access cycle.
- FINISH occurs one cycle after the last GAP; `irq` rises on the same edge that DONE sets.

## Test plan
- Fill: FILL=0xAA, DST=0x0100, CNT=3, START|MODE=0 → VPU writes $1=0x01, $2=0x00, $0=0xAA, then 0x0101, then 0x0102. DONE after 12+1 cycles, VRAM[0x100..0x102]=0xAA.
- Copy: VRAM[0x10..0x11]=0x12,0x34, SRC=0x10, DST=0x20, CNT=2, MODE=1, IEN=1 → VRAM[0x20..0x21]=0x12,0x34. `irq`=1 after 16+1 cycles; status read returns 0x46 and drops `irq`.
- Contention: `cpu_vcs` pulsed during the engine's DST_WR → CPU access reaches `vpu` unmodified. The byte restarts at DST_HI, and the final VRAM contents are still correct.
- Wrap: DST=0x1FFF, CNT=2 fill → writes 0x1FFF then 0x0000.
- Edge cases: CNT=0 START → DONE with zero `vpu_cs` pulses. START while BUSY is ignored. ABORT mid-copy → IDLE, DONE=0, `irq`=0.
- Reset: `rst` low mid-transfer → `vpu_cs` follows `cpu_vcs` only, BUSY=0, `irq`=0, registers read 0.
